// File: rtl/fetch_pkg.sv
// Shared constants and buffer entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH    = 32;
  localparam int unsigned PC_INC         = 4;
  localparam int unsigned PC_READ_OFFSET = 8;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] instr;
    logic [FETCH_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO between instruction memory and decode; the head entry
// drives the decode outputs straight from flops.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  input  logic       flush,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t mem [2];
  logic   rd_ptr;
  logic   wr_ptr;
  logic   do_pop;

  assign do_pop = pop & (count != 2'd0);
  assign head   = mem[rd_ptr];

  // When full, a push lands in the slot being popped in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues word reads to a synchronous imem and
// hands {instr, pc} to decode, absorbing back-pressure in a 2-entry buffer.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc,
  output logic [WIDTH-1:0] dec_pc_plus8
);

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] inflight_pc_q;
  logic             inflight_q;
  logic             kill_q;
  logic [1:0]       count;
  logic             pop;
  logic             push;
  logic [2:0]       occupancy;
  entry_t           push_data;
  entry_t           head;

  assign pop = dec_valid & dec_ready;

  // Entries held or owed after this cycle's pop; a new request must fit.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign imem_req  = !reset && !redirect && (occupancy < 3'd2);
  assign imem_addr = pc_q;

  assign push      = inflight_q & ~kill_q & ~redirect;
  assign push_data = '{instr: imem_rdata, pc: inflight_pc_q};

  fetch_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign dec_valid    = (count != 2'd0);
  assign dec_instr    = head.instr;
  assign dec_pc       = head.pc;
  assign dec_pc_plus8 = head.pc + WIDTH'(PC_READ_OFFSET);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      inflight_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      inflight_q <= imem_req;
      // Redirect already suppresses the request; kill guards the response anyway.
      kill_q     <= redirect & imem_req;
      if (imem_req) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + WIDTH'(PC_INC);
      end
      if (redirect) begin
        pc_q <= redirect_pc & ~WIDTH'(3);
      end
    end
  end

endmodule
